// File: rtl/sine_pkg.sv
// Shared constants, FSM encoding and the signed 24-entry sine table.
package sine_pkg;

    localparam int N_SAMPLES = 24;
    localparam int SAMPLE_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    localparam logic signed [SAMPLE_W-1:0] SINE_TABLE [N_SAMPLES] = '{
        8'sd0,   8'sd6,   8'sd12,  8'sd17,  8'sd21,  8'sd23,
        8'sd24,  8'sd23,  8'sd21,  8'sd17,  8'sd12,  8'sd6,
        -8'sd0,  -8'sd6,  -8'sd12, -8'sd17, -8'sd21, -8'sd23,
        -8'sd24, -8'sd23, -8'sd21, -8'sd17, -8'sd12, -8'sd6
    };

    // A zero step would stall the phase forever; a step of 24+ would skip whole periods.
    function automatic logic [4:0] clamp_step(input logic [4:0] s);
        if (s == 5'd0) return 5'd1;
        if (s > 5'd23) return 5'd23;
        return s;
    endfunction

endpackage

// File: rtl/sine_rom24.sv
// Combinational phase index to signed sample lookup; out-of-range indices read as 0.
module sine_rom24
    import sine_pkg::*;
(
    input  logic [4:0]                 idx_i,
    output logic signed [SAMPLE_W-1:0] sample_o
);

    always_comb begin
        sample_o = '0;
        if (idx_i < 5'd24) begin
            sample_o = SINE_TABLE[idx_i];
        end
    end

endmodule

// File: rtl/sine_seq_ctrl.sv
// Start/stop sequencer stepping a phase index through the sine table; one registered sample per clock.
// Runs always end on a wrapping sample; outputs clear on the edge after done.
module sine_seq_ctrl #(
    parameter int N_SAMPLES = 24,
    parameter int CNT_W     = 8
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic [4:0]                    step,
    input  logic [CNT_W-1:0]              periods,
    input  logic [1:0]                    shift,
    output logic [sine_pkg::SAMPLE_W-1:0] data_out,
    output logic                          data_valid,
    output logic                          busy,
    output logic                          wrap,
    output logic                          done
);
    import sine_pkg::*;

    state_e                state_q, state_d;
    logic [4:0]            idx_q, idx_d;
    logic [4:0]            step_q, step_d;
    logic [CNT_W-1:0]      per_q, per_d;
    logic [1:0]            shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]   data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  wrap_q, wrap_d;
    logic                  done_q, done_d;

    logic signed [SAMPLE_W-1:0] rom_s;
    logic signed [SAMPLE_W-1:0] shifted;
    logic [5:0]            sum;
    logic                  wrapping;
    logic [4:0]            idx_next;
    logic [CNT_W-1:0]      cnt_inc;
    logic [CNT_W-1:0]      cnt_next;
    logic                  last_period;

    sine_rom24 u_rom (
        .idx_i    (idx_q),
        .sample_o (rom_s)
    );

    assign shifted     = rom_s >>> shift_q;
    assign sum         = {1'b0, idx_q} + {1'b0, step_q};
    assign wrapping    = (sum >= 6'(N_SAMPLES));
    assign idx_next    = wrapping ? 5'(sum - 6'(N_SAMPLES)) : sum[4:0];
    assign cnt_inc     = cnt_q + CNT_W'(1);
    // Continuous mode pins the count at all-ones instead of rolling over.
    assign cnt_next    = (cnt_q == '1) ? cnt_q : cnt_inc;
    assign last_period = (per_q != '0) && (cnt_inc == per_q);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            step_q  <= '0;
            per_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            per_q   <= per_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = step_q;
        per_d   = per_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    step_d  = clamp_step(step);
                    per_d   = periods;
                    shift_d = shift;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_STOPPING: begin
                data_d  = shifted;
                valid_d = 1'b1;
                idx_d   = idx_next;
                if (wrapping) begin
                    wrap_d = 1'b1;
                    cnt_d  = cnt_next;
                end
                // A stop landing on a wrapping edge ends the run right there.
                if (wrapping && (last_period || state_q == ST_STOPPING || stop)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (state_q == ST_RUN && stop) begin
                    state_d = ST_STOPPING;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign wrap       = wrap_q;
    assign done       = done_q;
    assign busy       = (state_q != ST_IDLE) || valid_q;

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Scoreboard bench: a phase-arithmetic model predicts every sample; a monitor thread checks each output cycle.
module tb_sine_seq_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [4:0] step = '0;
    logic [7:0] periods = '0;
    logic [1:0] shift = '0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       wrap;
    logic       done;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [9:0]  exp_q[$];
    int          base_t [12] = '{0, 6, 12, 17, 21, 23, 24, 23, 21, 17, 12, 6};

    localparam int NO_STOP = 1 << 30;

    always #5 Clk = ~Clk;

    sine_seq_ctrl #(.N_SAMPLES(24), .CNT_W(8)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .periods    (periods),
        .shift      (shift),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .wrap       (wrap),
        .done       (done)
    );

    function automatic int tbl_val(input int i);
        return (i < 12) ? base_t[i] : -base_t[i-12];
    endfunction

    function automatic int fshift(input int v, input int sh);
        int d;
        int q;
        d = 1 << sh;
        q = v / d;
        if (v < 0 && (v % d) != 0) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Sample n sits at phase n*step; a wrap is a change in floor(phase/24) before the next sample.
    task automatic build_model(input int st, input int per, input int sh, input int stop_n,
                               output int len);
        int  eff;
        int  n;
        int  c0;
        int  c1;
        bit  w;
        bit  d;
        logic [7:0] v;
        eff = (st == 0) ? 1 : ((st > 23) ? 23 : st);
        n = 0;
        d = 1'b0;
        while (!d && n < 5000) begin
            c0 = (n * eff) / 24;
            c1 = ((n + 1) * eff) / 24;
            w  = (c1 != c0);
            d  = w && ((per != 0 && c1 == per) || n >= stop_n);
            v  = 8'(fshift(tbl_val((n * eff) % 24), sh));
            exp_q.push_back({v, w, d});
            n++;
        end
        len = n;
    endtask

    task automatic do_run(input int st, input int per, input int sh, input bit start_stop,
                          input int stop_n, input bit check_clear);
        int len;
        int cyc;
        bit seen;
        build_model(st, per, sh, stop_n, len);
        start   = 1'b1;
        stop    = start_stop;
        step    = 5'(st);
        periods = 8'(per);
        shift   = 2'(sh);
        @(posedge Clk); #1;
        start   = 1'b0;
        stop    = 1'b0;
        step    = 5'($urandom);
        periods = 8'($urandom);
        shift   = 2'($urandom);
        chk("start_busy_novalid", {30'd0, busy, data_valid}, 32'd2);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < len + 4) begin
            stop = (cyc == stop_n);
            @(posedge Clk); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        stop = 1'b0;
        chk("done_edge", cyc, len);
        if (check_clear) begin
            @(posedge Clk); #1;
            chk("clear_after_done", {data_valid, data_out, busy, wrap, done}, 32'd0);
        end
    endtask

    initial begin
        int len;
        int st;
        int per;
        int sn;

        fork
            forever begin
                logic [9:0] e;
                @(negedge Clk);
                if (Rst_n) begin
                    if (data_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_sample", {22'd0, data_out, wrap, done}, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("sample", {22'd0, data_out, wrap, done}, {22'd0, e});
                        end
                    end else begin
                        chk("idle_outputs", {22'd0, data_out, wrap, done}, 32'd0);
                    end
                end
            end
        join_none

        #1 Rst_n = 1'b0;
        #1 chk("reset_state", {data_valid, data_out, busy, wrap, done}, 32'd0);
        @(posedge Clk); @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        do_run(1, 1, 0, 1'b0, NO_STOP, 1'b1);
        do_run(7, 2, 0, 1'b0, NO_STOP, 1'b0);
        // Restart on the output-clear edge, then a continuous run stopped at idx 10.
        do_run(2, 0, 0, 1'b0, 89, 1'b1);
        do_run(6, 2, 2, 1'b0, NO_STOP, 1'b1);
        do_run(0, 1, 1, 1'b0, NO_STOP, 1'b1);
        do_run(31, 2, 3, 1'b0, NO_STOP, 1'b0);
        do_run(5, 1, 0, 1'b1, NO_STOP, 1'b1);
        do_run(23, 0, 0, 1'b0, 0, 1'b1);

        build_model(3, 4, 1, NO_STOP, len);
        start = 1'b1; step = 5'd3; periods = 8'd4; shift = 2'd1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (10) @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1 chk("async_reset_midrun", {data_valid, data_out, busy, wrap, done}, 32'd0);
        exp_q.delete();
        @(posedge Clk); @(posedge Clk); #1;
        Rst_n = 1'b1;
        do_run(4, 1, 0, 1'b0, NO_STOP, 1'b1);

        for (int r = 0; r < 12; r++) begin
            st  = int'($urandom_range(0, 31));
            per = int'($urandom_range(0, 3));
            sn  = (per == 0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 60)) : NO_STOP;
            do_run(st, per, int'($urandom_range(0, 3)), 1'($urandom), sn, 1'($urandom));
        end
        @(posedge Clk); @(posedge Clk); #1;

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
